// File: rtl/operand_fetch_sequencer_if.sv
// Register-file destination names and the operand-fetch bus shared by the
// decoder, memory port and register file.
package register_types;
   typedef enum logic [2:0] {
      NONE = 3'd0,
      OP0  = 3'd1,
      OP0L = 3'd2,
      OP0H = 3'd3,
      OP1  = 3'd4,
      OP1L = 3'd5,
      OP1H = 3'd6
   } name;
endpackage

interface operand_fetch_sequencer_if #(
   parameter int unsigned ADDR_W = 17
) ();
   logic                start;
   logic [1:0]          op0_kind;
   logic [1:0]          op1_kind;
   logic [ADDR_W-1:0]   ip_in;
   logic                mem_req;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_ack;
   logic [7:0]          mem_rdata;
   register_types::name mem_dest_select;
   logic [7:0]          mem_dest;
   logic                busy;
   logic                done;
   logic [ADDR_W-1:0]   ip_out;

   modport master (
      input  start, op0_kind, op1_kind, ip_in, mem_ack, mem_rdata,
      output mem_req, mem_addr, mem_dest_select, mem_dest, busy, done, ip_out
   );

   modport slave (
      output start, op0_kind, op1_kind, ip_in, mem_ack, mem_rdata,
      input  mem_req, mem_addr, mem_dest_select, mem_dest, busy, done, ip_out
   );
endinterface

// File: rtl/operand_fetch_sequencer.sv
// Fetches 0-2 operand bytes per operand from memory and writes them into OP0/OP1.
// Optional: define OPFETCH_SIGN_EXTEND_EN to sign-extend byte operands via an EXT write.
module operand_fetch_sequencer
   import register_types::*;
#(
   parameter int unsigned ADDR_W = 17
) (
   input logic                      clk,
   input logic                      rst,
   operand_fetch_sequencer_if.master bus
);

   localparam int unsigned LIST_N = 4;
   localparam int unsigned IDX_W  = 3;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WR   = 3'd2,
      S_EXT  = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   state_t            r_state, w_next;
   name               r_list [LIST_N];
   name               w_list [LIST_N];
   logic [IDX_W-1:0]  r_idx, w_idx;
   logic [IDX_W-1:0]  r_len, w_len;
   logic [ADDR_W-1:0] r_addr, w_addr;
   logic [ADDR_W-1:0] r_ip_out, w_ip_out;
   name               r_sel, w_sel;
   logic [7:0]        r_dest, w_dest;
   logic              r_mem_req;
   logic              r_busy;
   logic              r_done;

   // Next state plus next values of every registered output
   always_comb begin
      w_next   = r_state;
      w_list   = r_list;
      w_idx    = r_idx;
      w_len    = r_len;
      w_addr   = r_addr;
      w_ip_out = r_ip_out;
      w_sel    = NONE;
      w_dest   = r_dest;

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_len = '0;
               case (bus.op0_kind)
                  2'b01: begin
                     w_list[0] = OP0;
                     w_len     = IDX_W'(1);
                  end
                  2'b10: begin
                     w_list[0] = OP0L;
                     w_list[1] = OP0H;
                     w_len     = IDX_W'(2);
                  end
                  default: ;
               endcase
               // OP1 entries follow whatever OP0 occupied
               case (bus.op1_kind)
                  2'b01: begin
                     w_list[w_len[1:0]] = OP1;
                     w_len              = w_len + IDX_W'(1);
                  end
                  2'b10: begin
                     w_list[w_len[1:0]]         = OP1L;
                     w_list[w_len[1:0] + 2'd1]  = OP1H;
                     w_len                      = w_len + IDX_W'(2);
                  end
                  default: ;
               endcase
               w_idx  = '0;
               w_addr = bus.ip_in;
               w_next = (w_len == '0) ? S_FIN : S_REQ;
            end
         end
         S_REQ: begin
            if (bus.mem_ack) begin
               w_dest = bus.mem_rdata;
               w_sel  = r_list[r_idx[1:0]];
               w_idx  = r_idx + IDX_W'(1);
               w_addr = r_addr + ADDR_W'(1);
               w_next = S_WR;
            end
         end
         S_WR: begin
            w_next = (r_idx < r_len) ? S_REQ : S_FIN;
`ifdef OPFETCH_SIGN_EXTEND_EN
            if (((r_sel == OP0) || (r_sel == OP1)) && r_dest[7]) begin
               w_next = S_EXT;
               w_sel  = (r_sel == OP0) ? OP0H : OP1H;
               w_dest = 8'hFF;
            end
`endif
         end
         S_EXT: begin
            w_next = (r_idx < r_len) ? S_REQ : S_FIN;
         end
         S_FIN: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase

      if (w_next == S_FIN) begin
         w_ip_out = w_addr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Registered datapath and handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LIST_N; i++) begin
            r_list[i] <= NONE;
         end
         r_idx     <= '0;
         r_len     <= '0;
         r_addr    <= '0;
         r_ip_out  <= '0;
         r_sel     <= NONE;
         r_dest    <= '0;
         r_mem_req <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_list    <= w_list;
         r_idx     <= w_idx;
         r_len     <= w_len;
         r_addr    <= w_addr;
         r_ip_out  <= w_ip_out;
         r_sel     <= w_sel;
         r_dest    <= w_dest;
         r_mem_req <= (w_next == S_REQ);
         r_busy    <= (w_next == S_REQ) || (w_next == S_WR) || (w_next == S_EXT);
         r_done    <= (w_next == S_FIN);
      end
   end

   assign bus.mem_req         = r_mem_req;
   assign bus.mem_addr        = r_addr;
   assign bus.mem_dest_select = r_sel;
   assign bus.mem_dest        = r_dest;
   assign bus.busy            = r_busy;
   assign bus.done            = r_done;
   assign bus.ip_out          = r_ip_out;

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Directed and randomized checks of operand_fetch_sequencer against a
// write-list reference model; honours OPFETCH_SIGN_EXTEND_EN like the design.
module tb_operand_fetch_sequencer;
   import register_types::*;

   localparam int unsigned ADDR_W = 17;
   localparam int unsigned MEM_N  = 1 << ADDR_W;

   typedef struct packed {
      name        sel;
      logic [7:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   operand_fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   operand_fetch_sequencer #(.ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0]        mem [MEM_N];
   wr_t               obs_q [$];
   wr_t               exp_q [$];
   int                n_asserts = 0;
   int                n_fail    = 0;
   int                ack_delay = 0;
   bit                spurious  = 0;
   bit                done_seen = 0;
   int                done_cyc  = 0;
   logic [ADDR_W-1:0] done_ip;
   int                req_cycles = 0;
   logic [ADDR_W-1:0] exp_ip;
   int                exp_bytes;
   int                exp_ext;

   int                rs_wait;
   int                rs_delay;
   bit                rs_in_req  = 0;
   bit                rs_prev_wt = 0;
   logic [ADDR_W-1:0] rs_prev_addr;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_asserts++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Memory responder: per-request ack latency, optional junk acks while idle
   initial begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst && bus.mem_req) begin
            if (rs_prev_wt) check("addr_stable", 32'(bus.mem_addr), 32'(rs_prev_addr));
            if (!rs_in_req) begin
               rs_in_req = 1;
               rs_wait   = 0;
               rs_delay  = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
            end
            if (rs_wait >= rs_delay) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mem[bus.mem_addr];
               rs_in_req     = 0;
               rs_prev_wt    = 0;
            end else begin
               bus.mem_ack   = 1'b0;
               bus.mem_rdata = 8'($urandom);
               rs_wait++;
               rs_prev_wt    = 1;
               rs_prev_addr  = bus.mem_addr;
            end
         end else begin
            rs_in_req     = 0;
            rs_prev_wt    = 0;
            bus.mem_ack   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_rdata = 8'($urandom);
         end
      end
   end

   // Monitor: collects register-file writes, done pulses and request cycles
   initial begin
      wr_t w;
      forever begin
         @(negedge clk);
         if (bus.mem_dest_select != NONE) begin
            w.sel  = bus.mem_dest_select;
            w.data = bus.mem_dest;
            obs_q.push_back(w);
         end
         if (bus.mem_req) req_cycles++;
         if (bus.done) begin
            done_seen = 1;
            done_cyc  = cyc;
            done_ip   = bus.ip_out;
         end
      end
   end

   // Reference: expected write list built straight from the operand kinds
   task automatic model(input logic [1:0] k0, input logic [1:0] k1, input logic [ADDR_W-1:0] ip);
      int         off;
      logic [1:0] kind;
      logic [7:0] d;
      wr_t        w;
      exp_q.delete();
      off     = 0;
      exp_ext = 0;
      for (int op = 0; op < 2; op++) begin
         kind = (op == 0) ? k0 : k1;
         if (kind == 2'b01) begin
            d      = mem[ip + ADDR_W'(off)];
            w.sel  = (op == 0) ? OP0 : OP1;
            w.data = d;
            exp_q.push_back(w);
            off++;
`ifdef OPFETCH_SIGN_EXTEND_EN
            if (d[7]) begin
               w.sel  = (op == 0) ? OP0H : OP1H;
               w.data = 8'hFF;
               exp_q.push_back(w);
               exp_ext++;
            end
`endif
         end else if (kind == 2'b10) begin
            w.sel  = (op == 0) ? OP0L : OP1L;
            w.data = mem[ip + ADDR_W'(off)];
            exp_q.push_back(w);
            w.sel  = (op == 0) ? OP0H : OP1H;
            w.data = mem[ip + ADDR_W'(off + 1)];
            exp_q.push_back(w);
            off += 2;
         end
      end
      exp_bytes = off;
      exp_ip    = ip + ADDR_W'(off);
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, "_mem_req"}, 32'(bus.mem_req), 32'd0);
      check({pfx, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
      check({pfx, "_sel"}, 32'(bus.mem_dest_select), 32'(NONE));
      check({pfx, "_dest"}, 32'(bus.mem_dest), 32'd0);
      check({pfx, "_busy"}, 32'(bus.busy), 32'd0);
      check({pfx, "_done"}, 32'(bus.done), 32'd0);
      check({pfx, "_ip_out"}, 32'(bus.ip_out), 32'd0);
   endtask

   task automatic run_txn(input logic [1:0] k0, input logic [1:0] k1,
                          input logic [ADDR_W-1:0] ip, input bit poke);
      int c0;
      int lat;
      model(k0, k1, ip);
      obs_q.delete();
      done_seen  = 0;
      req_cycles = 0;
      bus.start    = 1'b1;
      bus.op0_kind = k0;
      bus.op1_kind = k1;
      bus.ip_in    = ip;
      c0 = cyc;
      tick();
      bus.start = 1'b0;
      check("busy_after_start", 32'(bus.busy), 32'(exp_bytes > 0));
      for (int i = 0; i < 400 && !done_seen; i++) begin
         if (poke && (i % 3 == 1)) begin
            bus.start    = 1'b1;
            bus.op0_kind = 2'($urandom);
            bus.op1_kind = 2'($urandom);
            bus.ip_in    = ADDR_W'($urandom);
         end
         tick();
         bus.start = 1'b0;
      end
      check("done_seen", 32'(done_seen), 32'd1);
      if (done_seen) begin
         lat = (exp_bytes == 0) ? 1 : (2 * exp_bytes + 1 + exp_ext);
         if (ack_delay == 0) begin
            check("done_latency", 32'(done_cyc - c0), 32'(lat));
            check("req_cycles", 32'(req_cycles), 32'(exp_bytes));
         end
         check("ip_out", 32'(done_ip), 32'(exp_ip));
         check("busy_at_done", 32'(bus.busy), 32'd0);
         check("write_count", 32'(obs_q.size()), 32'(exp_q.size()));
         for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
               check($sformatf("wr%0d_sel", i), 32'(obs_q[i].sel), 32'(exp_q[i].sel));
               check($sformatf("wr%0d_data", i), 32'(obs_q[i].data), 32'(exp_q[i].data));
            end
         end
      end
      // start presented during FIN must be dropped
      if (poke) begin
         bus.start    = 1'b1;
         bus.op0_kind = 2'b10;
         bus.op1_kind = 2'b10;
      end
      tick();
      bus.start = 1'b0;
      check("done_pulse", 32'(bus.done), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_req", 32'(bus.mem_req), 32'd0);
      check("ip_held", 32'(bus.ip_out), 32'(exp_ip));
      tick();
      tick();
      check("no_extra_wr", 32'(obs_q.size()), 32'(exp_q.size()));
      if (exp_q.size() > 0)
         check("dest_hold", 32'(bus.mem_dest), 32'(exp_q[exp_q.size()-1].data));
   endtask

   initial begin
      bit hit;
      for (int a = 0; a < int'(MEM_N); a++) mem[a] = 8'($urandom);
      bus.start    = 1'b0;
      bus.op0_kind = 2'b00;
      bus.op1_kind = 2'b00;
      bus.ip_in    = '0;

      #1 rst = 1'b1;
      tick();
      check_reset("por");
      tick();
      rst = 1'b0;
      tick();

      // none/none completes the cycle after start
      ack_delay = 0;
      run_txn(2'b00, 2'b00, 17'h0ABCD, 1'b0);
      run_txn(2'b11, 2'b11, 17'h01234, 1'b0);

      // byte + word
      mem[17'h00100] = 8'h12;
      mem[17'h00101] = 8'h34;
      mem[17'h00102] = 8'h56;
      run_txn(2'b01, 2'b10, 17'h00100, 1'b0);

      // address wrap
      mem[17'h1FFFF] = 8'hA5;
      mem[17'h00000] = 8'h5A;
      run_txn(2'b10, 2'b00, 17'h1FFFF, 1'b0);
      run_txn(2'b10, 2'b10, 17'h04000, 1'b0);

      // slow acks, junk acks while idle, ignored mid-sequence starts
      ack_delay = 3;
      spurious  = 1;
      repeat (4) tick();
      run_txn(2'b10, 2'b01, 17'h08000, 1'b1);
      spurious  = 0;

      // reset during the request of the second byte
      ack_delay = 2;
      obs_q.delete();
      done_seen    = 0;
      bus.start    = 1'b1;
      bus.op0_kind = 2'b10;
      bus.op1_kind = 2'b01;
      bus.ip_in    = 17'h03000;
      tick();
      bus.start = 1'b0;
      hit = 0;
      for (int i = 0; i < 100; i++) begin
         if (obs_q.size() == 1 && bus.mem_req) begin
            hit = 1;
            break;
         end
         tick();
      end
      check("rst_reached_req2", 32'(hit), 32'd1);
      rst = 1'b1;
      #1;
      check_reset("midrst");
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("rst_no_done", 32'(done_seen), 32'd0);
      check("rst_no_writes", 32'(obs_q.size()), 32'd1);
      ack_delay = 0;
      run_txn(2'b10, 2'b01, 17'h03000, 1'b0);

      // byte operands with bit7 set / clear
      mem[17'h02000] = 8'h80;
      mem[17'h02001] = 8'h7F;
      mem[17'h02002] = 8'hC3;
      run_txn(2'b01, 2'b00, 17'h02000, 1'b0);
      run_txn(2'b01, 2'b01, 17'h02001, 1'b0);
      run_txn(2'b00, 2'b01, 17'h02000, 1'b0);

      // randomized transactions
      for (int t = 0; t < 24; t++) begin
         ack_delay = ($urandom_range(0, 1) == 0) ? 0 : -1;
         spurious  = 1'($urandom_range(0, 1));
         run_txn(2'($urandom), 2'($urandom), ADDR_W'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
